// File: rtl/ext_alu_seq.sv
// Sequencer for multi-cycle ext-ALU ops: stalls the pipe, launches the unit and pulses result/flag captures.
// Optional macro EXT_SEQ_ILLEGAL_EN: func=111 is rejected and sets a sticky err instead of running as a 1-cycle op.
module ext_alu_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] func,
    input  logic       flush,
    output logic       stall_ext,
    output logic       busy,
    output logic       unit_go,
    output logic [2:0] unit_func,
    output logic       res_we,
    output logic       clk_z_ext,
    output logic       clk_nv_ext,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] func_q, func_d;
    logic       go_q;
    logic       open_w;
    logic       legal_w;
    logic       accept_w;
    logic       done_live_w;
    logic       flag_op_w;

    // Counter preload is latency minus one: RUN lasts exactly L cycles.
    function automatic logic [2:0] lat_m1(input logic [2:0] f);
        logic [2:0] r;
        case (f)
            3'b000, 3'b001: r = 3'd1;
            3'b010, 3'b011: r = 3'd2;
            3'b100:         r = 3'd3;
            default:        r = 3'd0;
        endcase
        return r;
    endfunction

`ifdef EXT_SEQ_ILLEGAL_EN
    assign legal_w = (func != 3'b111);
`else
    assign legal_w = 1'b1;
`endif

    assign open_w   = (state_q == IDLE) || (state_q == DONE);
    assign accept_w = open_w && start && !flush && legal_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        case (state_q)
            IDLE: begin
                if (accept_w) begin
                    state_d = RUN;
                    cnt_d   = lat_m1(func);
                    func_d  = func;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else if (cnt_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                // Back-to-back issue: a new op may be accepted while the old one retires.
                if (accept_w) begin
                    state_d = RUN;
                    cnt_d   = lat_m1(func);
                    func_d  = func;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            func_q  <= 3'd0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            go_q    <= accept_w;
        end
    end

`ifdef EXT_SEQ_ILLEGAL_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (open_w && start && !flush && (func == 3'b111)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Flush in DONE squashes the retiring op's writes.
    assign done_live_w = (state_q == DONE) && !flush;
    assign flag_op_w   = (func_q <= 3'b100);

    // Gated by rst_n so the pipe is never stalled while reset is held.
    assign stall_ext  = rst_n && (accept_w || (state_q == RUN));
    assign busy       = (state_q != IDLE);
    assign unit_go    = go_q;
    assign unit_func  = func_q;
    assign res_we     = done_live_w;
    assign clk_z_ext  = done_live_w && flag_op_w;
    assign clk_nv_ext = done_live_w && flag_op_w;

endmodule

// File: tb/tb_ext_alu_seq.sv
// Table-driven bench for ext_alu_seq with a completion scoreboard on res_we.
module tb_ext_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] func;
    logic       flush;
    logic       stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err;
    logic [2:0] unit_func;

    ext_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .func       (func),
        .flush      (flush),
        .stall_ext  (stall_ext),
        .busy       (busy),
        .unit_go    (unit_go),
        .unit_func  (unit_func),
        .res_we     (res_we),
        .clk_z_ext  (clk_z_ext),
        .clk_nv_ext (clk_nv_ext),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [2:0] func;
        logic       flush;
        logic       stall;
        logic       busy;
        logic       go;
        logic       we;
        logic       flg;
        logic       acc;   // op accepted this cycle: push its expected completion
        logic       kill;  // pending op aborted this cycle: drop its completion
    } vec_t;

    typedef struct {
        logic [2:0] func;
        logic       flg;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_err = 1'b0;

    function automatic vec_t v(input logic s, input logic [2:0] f, input logic fl,
                               input logic st, input logic b, input logic g,
                               input logic w, input logic fg, input logic a, input logic k);
        vec_t r;
        r.start = s; r.func = f; r.flush = fl;
        r.stall = st; r.busy = b; r.go = g; r.we = w; r.flg = fg;
        r.acc = a; r.kill = k;
        return r;
    endfunction

    task automatic check_vec(input vec_t t, input string tag);
        logic [6:0] got, want;
        sb_t e;
        sb_t n;
        #1;
        got  = {stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err};
        want = {t.stall, t.busy, t.go, t.we, t.flg, t.flg, exp_err};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s outs{stall,busy,go,we,z,nv,err} got %b want %b", tag, got, want);
        end
        if (res_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s sb unexpected res_we (unit_func=%0d)", tag, unit_func);
            end else begin
                e = sb.pop_front();
                if (unit_func !== e.func || clk_z_ext !== e.flg) begin
                    errors++;
                    $display("FAIL %s sb got func=%0d flg=%b want func=%0d flg=%b",
                             tag, unit_func, clk_z_ext, e.func, e.flg);
                end else begin
                    $display("txn func=%0d retired at %0t", e.func, $time);
                end
            end
        end
        if (t.kill && sb.size() > 0) begin
            void'(sb.pop_front());
        end
        if (t.acc) begin
            n.func = t.func;
            n.flg  = (t.func <= 3'b100);
            sb.push_back(n);
        end
    endtask

    task automatic step(input vec_t t, input string tag);
        @(negedge clk);
        start = t.start;
        func  = t.func;
        flush = t.flush;
        check_vec(t, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        func  = 3'd0;
        flush = 1'b0;
        #1;
        checks++;
        if ({stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err, unit_func} !== 10'd0) begin
            errors++;
            $display("FAIL reset outs got %b want 0",
                     {stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err, unit_func});
        end
        @(negedge clk);
        rst_n = 1'b1;

        // args: start func flush | stall busy go we flg | acc kill
        // MUL: stall 3 cycles, go after 1, retire with flags after L+1
        tbl.push_back(v(1, 3'd0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // UMUL with start held during RUN (ignored)
        tbl.push_back(v(1, 3'd1, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 3'd5, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 3'd5, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd5, 0, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // MULF then ITF issued in DONE, no bubble
        tbl.push_back(v(1, 3'd4, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 3'd5, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ADDF flushed in RUN
        tbl.push_back(v(1, 3'd2, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 1, 1, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ITF flushed in DONE, flush also blocks the new start
        tbl.push_back(v(1, 3'd5, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 3'd0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // start with flush in IDLE: not accepted
        tbl.push_back(v(1, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
        // SUBF then FTI back-to-back
        tbl.push_back(v(1, 3'd3, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 3'd6, 0, 1, 1, 0, 1, 1, 1, 0));
        tbl.push_back(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // func=111 handling depends on the build
`ifdef EXT_SEQ_ILLEGAL_EN
        step(v(1, 3'd7, 0, 0, 0, 0, 0, 0, 0, 0), "ill_start");
        exp_err = 1'b1;
        step(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_err");
        step(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_sticky1");
        step(v(1, 3'd0, 0, 1, 0, 0, 0, 0, 1, 0), "ill_then_mul");
        step(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0), "ill_mul_go");
        step(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0), "ill_mul_run");
        step(v(0, 3'd0, 0, 0, 1, 0, 1, 1, 0, 0), "ill_mul_done");
`else
        step(v(1, 3'd7, 0, 1, 0, 0, 0, 0, 1, 0), "f7_start");
        step(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0), "f7_go");
        step(v(0, 3'd0, 0, 0, 1, 0, 1, 0, 0, 0), "f7_done");
`endif
        step(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), "f7_idle");

        // SUBF interrupted by reset in RUN, then MUL right after release
        step(v(1, 3'd3, 0, 1, 0, 0, 0, 0, 1, 0), "rst_subf");
        step(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0), "rst_go");
        @(negedge clk);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err, unit_func} !== 10'd0) begin
            errors++;
            $display("FAIL midrun_reset outs got %b want 0",
                     {stall_ext, busy, unit_go, res_we, clk_z_ext, clk_nv_ext, err, unit_func});
        end
        if (sb.size() > 0) void'(sb.pop_front());
        exp_err = 1'b0;
        step(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        func  = 3'd0;
        flush = 1'b0;
        check_vec(v(1, 3'd0, 0, 1, 0, 0, 0, 0, 1, 0), "rel_mul");
        step(v(0, 3'd0, 0, 1, 1, 1, 0, 0, 0, 0), "rel_go");
        step(v(0, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0), "rel_run");
        step(v(0, 3'd0, 0, 0, 1, 0, 1, 1, 0, 0), "rel_done");
        step(v(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0), "rel_idle");
        checks++;
        if (unit_func !== 3'd0) begin
            errors++;
            $display("FAIL unit_func_hold got %0d want 0", unit_func);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
